// File: rtl/i2s_tx_fifo_if.sv
// Sample-pair write bus from the interpolation path into the I2S transmitter FIFO.
interface i2s_tx_fifo_if;
  logic [23:0] APSDATA_LEFT_i;
  logic [23:0] APSDATA_RIGHT_i;
  logic        APDATA_VALID_i;

  modport master (output APSDATA_LEFT_i, APSDATA_RIGHT_i, APDATA_VALID_i);
  modport slave  (input  APSDATA_LEFT_i, APSDATA_RIGHT_i, APDATA_VALID_i);
endinterface

// File: rtl/i2s_tx_fifo.sv
// Philips I2S master transmitter: BCK/WS generated from AMCLK, 24-bit stereo pairs
// buffered in a small FIFO and popped once per 64-BCK frame.
module i2s_tx_fifo #(
  parameter int unsigned BCK_HALF_DIV = 4,
  parameter int unsigned FIFO_AW      = 2
) (
  input  logic               AMCLK_i,
  input  logic               ARST,
  i2s_tx_fifo_if.slave       i_wr,
  output logic               I2S_BCK,
  output logic               I2S_WS,
  output logic               I2S_DATA,
  output logic [FIFO_AW:0]   FIFO_LEVEL_o,
  output logic               UNDERRUN_o,
  output logic               OVERRUN_o
);

  localparam int unsigned Depth = 2 ** FIFO_AW;
  localparam int unsigned DivW  = (BCK_HALF_DIV > 1) ? $clog2(BCK_HALF_DIV) : 1;
  localparam logic [DivW-1:0]  DivLast = DivW'(BCK_HALF_DIV - 1);
  localparam logic [FIFO_AW:0] LvlFull = {1'b1, {FIFO_AW{1'b0}}};

  logic [DivW-1:0]    r_div_cnt;
  logic               r_bck;
  logic [5:0]         r_bit_cnt;
  logic               r_ws;
  logic               r_data;
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [FIFO_AW:0]   r_level;
  logic [23:0]        r_held_l;
  logic [23:0]        r_held_r;
  logic               r_underrun;
  logic               r_overrun;
  logic [47:0]        r_mem [Depth];

  logic               w_div_tc;
  logic               w_fall;
  logic [5:0]         w_bit_nxt;
  logic               w_frame_start;
  logic               w_empty;
  logic               w_full;
  logic               w_pop;
  logic               w_push;
  logic               w_drop;
  logic [23:0]        w_head_l;
  logic [23:0]        w_head_r;
  logic [23:0]        w_cur_l;
  logic [23:0]        w_cur_r;
  logic [23:0]        w_sample;
  logic [4:0]         w_pos;
  logic [4:0]         w_idx;
  logic               w_bit;
  logic [FIFO_AW:0]   w_level_nxt;

  assign w_div_tc      = (r_div_cnt == DivLast);
  assign w_fall        = w_div_tc & r_bck;
  assign w_bit_nxt     = r_bit_cnt + 6'd1;
  assign w_frame_start = w_fall & (w_bit_nxt == 6'd0);
  assign w_empty       = (r_level == '0);
  assign w_full        = (r_level == LvlFull);
  assign w_pop         = w_frame_start & ~w_empty;
  // A full FIFO still accepts a write on the cycle it pops.
  assign w_push        = i_wr.APDATA_VALID_i & (~w_full | w_pop);
  assign w_drop        = i_wr.APDATA_VALID_i & w_full & ~w_pop;

  assign {w_head_l, w_head_r} = r_mem[r_rd_ptr];
  assign w_cur_l  = w_pop ? w_head_l : r_held_l;
  assign w_cur_r  = w_pop ? w_head_r : r_held_r;
  assign w_sample = w_bit_nxt[5] ? w_cur_r : w_cur_l;
  assign w_pos    = w_bit_nxt[4:0];
  assign w_idx    = 5'd24 - w_pos;

  // Slot position 0 is the I2S one-bit delay; 25..31 are zero padding.
  always_comb begin
    w_bit = 1'b0;
    if ((w_pos >= 5'd1) && (w_pos <= 5'd24)) begin
      w_bit = w_sample[w_idx];
    end
  end

  always_comb begin
    w_level_nxt = r_level;
    if (w_push && !w_pop) begin
      w_level_nxt = r_level + (FIFO_AW + 1)'(1);
    end else if (w_pop && !w_push) begin
      w_level_nxt = r_level - (FIFO_AW + 1)'(1);
    end
  end

  always_ff @(posedge AMCLK_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {i_wr.APSDATA_LEFT_i, i_wr.APSDATA_RIGHT_i};
    end
  end

  always_ff @(posedge AMCLK_i or posedge ARST) begin
    if (ARST) begin
      r_div_cnt  <= '0;
      r_bck      <= 1'b0;
      r_bit_cnt  <= 6'd63;
      r_ws       <= 1'b1;
      r_data     <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_held_l   <= '0;
      r_held_r   <= '0;
      r_underrun <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_div_cnt <= w_div_tc ? '0 : r_div_cnt + DivW'(1);
      if (w_div_tc) begin
        r_bck <= ~r_bck;
      end
      if (w_fall) begin
        r_bit_cnt <= w_bit_nxt;
        r_ws      <= w_bit_nxt[5];
        r_data    <= w_bit;
      end
      if (w_pop) begin
        r_held_l <= w_head_l;
        r_held_r <= w_head_r;
        r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
      end
      r_level    <= w_level_nxt;
      r_underrun <= w_frame_start & w_empty;
      r_overrun  <= w_drop;
    end
  end

  assign I2S_BCK      = r_bck;
  assign I2S_WS       = r_ws;
  assign I2S_DATA     = r_data;
  assign FIFO_LEVEL_o = r_level;
  assign UNDERRUN_o   = r_underrun;
  assign OVERRUN_o    = r_overrun;

endmodule

// File: tb/tb_i2s_tx_fifo.sv
// Bench for i2s_tx_fifo: directed tables on a BCK_HALF_DIV=4 instance, random traffic on
// BCK_HALF_DIV=1 and 6, every instance scored by a frame-level model and I2S receiver.
`timescale 1ns/1ps
module tb_i2s_tx_fifo;
  localparam int Aw    = 2;
  localparam int Depth = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // AMCLK edges since reset release; edge n is the n-th rising edge after release.
  int ecnt;
  always @(posedge clk or posedge rst) begin
    if (rst) ecnt <= 0;
    else     ecnt <= ecnt + 1;
  end

  int n_vec = 0;
  int n_err = 0;

  logic        v0 = 1'b0, v1 = 1'b0, v2 = 1'b0;
  logic [23:0] l0 = '0, r0 = '0, l1 = '0, r1 = '0, l2 = '0, r2 = '0;
  logic [2:0]  o_bck, o_ws, o_data, o_unr, o_ovr;
  logic [Aw:0] o_lvl [3];

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int D = (g == 0) ? 4 : ((g == 1) ? 1 : 6);

    i2s_tx_fifo_if u_if ();
    assign u_if.APDATA_VALID_i  = (g == 0) ? v0 : ((g == 1) ? v1 : v2);
    assign u_if.APSDATA_LEFT_i  = (g == 0) ? l0 : ((g == 1) ? l1 : l2);
    assign u_if.APSDATA_RIGHT_i = (g == 0) ? r0 : ((g == 1) ? r1 : r2);

    i2s_tx_fifo #(.BCK_HALF_DIV(D), .FIFO_AW(Aw)) u_dut (
      .AMCLK_i      (clk),
      .ARST         (rst),
      .i_wr         (u_if),
      .I2S_BCK      (o_bck[g]),
      .I2S_WS       (o_ws[g]),
      .I2S_DATA     (o_data[g]),
      .FIFO_LEVEL_o (o_lvl[g]),
      .UNDERRUN_o   (o_unr[g]),
      .OVERRUN_o    (o_ovr[g])
    );

    logic [47:0] q [$];
    logic [47:0] frames [$];
    logic [47:0] held;
    int          cyc, exp_lvl, rx_k;
    logic        exp_unr, exp_ovr, prev_bck;
    logic [63:0] rx_w;

    // Bits of one frame as they appear on the wire, bit 0 first.
    function automatic logic [63:0] wire_word(input logic [47:0] p);
      return {1'b0, p[47:24], 7'd0, 1'b0, p[23:0], 7'd0};
    endfunction

    // Reference model: frame starts on a fixed schedule; pop happens before the write.
    initial begin
      logic fs, was_full, popped;
      forever begin
        @(posedge clk);
        if (rst) begin
          q.delete();
          frames.delete();
          held = '0; cyc = 0; exp_lvl = 0; exp_unr = 1'b0; exp_ovr = 1'b0;
        end else begin
          cyc++;
          fs = (cyc >= 2 * D) && (((cyc - 2 * D) % (128 * D)) == 0);
          was_full = (q.size() == Depth);
          popped = 1'b0; exp_unr = 1'b0; exp_ovr = 1'b0;
          if (fs) begin
            if (q.size() != 0) begin
              held = q.pop_front();
              popped = 1'b1;
            end else begin
              exp_unr = 1'b1;
            end
            frames.push_back(held);
          end
          if (u_if.APDATA_VALID_i) begin
            if (!was_full || popped) q.push_back({u_if.APSDATA_LEFT_i, u_if.APSDATA_RIGHT_i});
            else exp_ovr = 1'b1;
          end
          exp_lvl = q.size();
        end
      end
    end

    // Per-cycle checks plus an I2S receiver sampling DATA on each BCK rise.
    initial begin
      int b, f;
      forever begin
        @(negedge clk);
        if (rst) begin
          rx_k = 0;
          prev_bck = 1'b0;
        end else begin
          f = cyc / (2 * D);
          chk1($sformatf("bck_d%0d", D), o_bck[g], ((cyc / D) % 2) == 1);
          chk1($sformatf("ws_d%0d", D), o_ws[g], (f == 0) ? 1'b1 : (((f - 1) % 64) >= 32));
          chk1($sformatf("underrun_d%0d", D), o_unr[g], exp_unr);
          chk1($sformatf("overrun_d%0d", D), o_ovr[g], exp_ovr);
          chk64($sformatf("level_d%0d", D), 64'(o_lvl[g]), 64'(exp_lvl));
          if (o_bck[g] && !prev_bck) begin
            if (rx_k > 0) begin
              b = (rx_k - 1) % 64;
              rx_w[63 - b] = o_data[g];
              if (b == 63) begin
                if (frames.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL frame_d%0d: frame ended with no expected pair", D);
                end else begin
                  chk64($sformatf("frame_d%0d", D), rx_w, wire_word(frames.pop_front()));
                end
              end
            end
            rx_k++;
          end
          prev_bck = o_bck[g];
        end
      end
    end
  end

  // Random traffic for the BCK_HALF_DIV=1 and 6 instances, alternating busy and sparse.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      v1 = ($urandom_range(0, ((ecnt / 700) % 2 == 1) ? 200 : 30) == 0);
      l1 = 24'($urandom);
      r1 = 24'($urandom);
      v2 = ($urandom_range(0, ((ecnt / 2000) % 2 == 1) ? 1500 : 90) == 0);
      l2 = 24'($urandom);
      r2 = 24'($urandom);
    end
  end

  initial begin
    #1_000_000;
    n_vec++;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "time limit");
  end

  typedef struct { int e; logic bck; logic ws; logic data; logic unr; } wire_vec_t;
  typedef struct { logic v; logic [23:0] l; logic [23:0] r; int lvl; logic ovr; } wr_vec_t;

  task automatic goto(input int n);
    while (ecnt < n) @(negedge clk);
  endtask

  task automatic reset_values(input string tag);
    chk1({tag, "_bck"}, o_bck[0], 1'b0);
    chk1({tag, "_ws"}, o_ws[0], 1'b1);
    chk1({tag, "_data"}, o_data[0], 1'b0);
    chk1({tag, "_unr"}, o_unr[0], 1'b0);
    chk1({tag, "_ovr"}, o_ovr[0], 1'b0);
    chk64({tag, "_level"}, 64'(o_lvl[0]), 64'd0);
  endtask

  initial begin
    wire_vec_t wv [18];
    wr_vec_t   bv [6];
    // L=0x800001, R=0x7FFFFE written on edge 2; frame starts at edge 8, one bit per 8 edges.
    wv[0]  = '{3,   1'b0, 1'b1, 1'b0, 1'b0};
    wv[1]  = '{4,   1'b1, 1'b1, 1'b0, 1'b0};
    wv[2]  = '{7,   1'b1, 1'b1, 1'b0, 1'b0};
    wv[3]  = '{8,   1'b0, 1'b0, 1'b0, 1'b0};
    wv[4]  = '{15,  1'b1, 1'b0, 1'b0, 1'b0};
    wv[5]  = '{16,  1'b0, 1'b0, 1'b1, 1'b0};
    wv[6]  = '{24,  1'b0, 1'b0, 1'b0, 1'b0};
    wv[7]  = '{192, 1'b0, 1'b0, 1'b0, 1'b0};
    wv[8]  = '{200, 1'b0, 1'b0, 1'b1, 1'b0};
    wv[9]  = '{208, 1'b0, 1'b0, 1'b0, 1'b0};
    wv[10] = '{256, 1'b0, 1'b0, 1'b0, 1'b0};
    wv[11] = '{264, 1'b0, 1'b1, 1'b0, 1'b0};
    wv[12] = '{272, 1'b0, 1'b1, 1'b0, 1'b0};
    wv[13] = '{280, 1'b0, 1'b1, 1'b1, 1'b0};
    wv[14] = '{448, 1'b0, 1'b1, 1'b1, 1'b0};
    wv[15] = '{456, 1'b0, 1'b1, 1'b0, 1'b0};
    wv[16] = '{464, 1'b0, 1'b1, 1'b0, 1'b0};
    wv[17] = '{519, 1'b1, 1'b1, 1'b0, 1'b0};
    bv[0] = '{1'b1, 24'h111111, 24'hEEEEEE, 1, 1'b0};
    bv[1] = '{1'b1, 24'h222222, 24'hDDDDDD, 2, 1'b0};
    bv[2] = '{1'b1, 24'h333333, 24'hCCCCCC, 3, 1'b0};
    bv[3] = '{1'b1, 24'h444444, 24'hBBBBBB, 4, 1'b0};
    bv[4] = '{1'b1, 24'h555555, 24'hAAAAAA, 4, 1'b1};
    bv[5] = '{1'b0, 24'h000000, 24'h000000, 4, 1'b0};

    repeat (10) @(negedge clk);
    reset_values("rst");
    #1 rst = 1'b0;

    goto(1);
    #1 v0 = 1'b1; l0 = 24'h800001; r0 = 24'h7FFFFE;
    goto(2);
    #1 v0 = 1'b0;
    for (int i = 0; i < 18; i++) begin
      goto(wv[i].e);
      chk1($sformatf("wire_bck@%0d", wv[i].e), o_bck[0], wv[i].bck);
      chk1($sformatf("wire_ws@%0d", wv[i].e), o_ws[0], wv[i].ws);
      chk1($sformatf("wire_data@%0d", wv[i].e), o_data[0], wv[i].data);
      chk1($sformatf("wire_unr@%0d", wv[i].e), o_unr[0], wv[i].unr);
    end
    goto(520);
    chk1("underrun_repeat", o_unr[0], 1'b1);
    goto(521);
    chk1("underrun_pulse_end", o_unr[0], 1'b0);

    // Five back-to-back writes into an empty FIFO between frame starts.
    goto(529);
    for (int i = 0; i < 6; i++) begin
      goto(529 + i);
      #1 v0 = bv[i].v; l0 = bv[i].l; r0 = bv[i].r;
      goto(530 + i);
      chk64($sformatf("burst_level%0d", i), 64'(o_lvl[0]), 64'(bv[i].lvl));
      chk1($sformatf("burst_ovr%0d", i), o_ovr[0], bv[i].ovr);
    end

    // Write while full on the exact frame-start pop.
    goto(1031);
    #1 v0 = 1'b1; l0 = 24'h666666; r0 = 24'h999999;
    goto(1032);
    chk64("popwrite_level", 64'(o_lvl[0]), 64'd4);
    chk1("popwrite_ovr", o_ovr[0], 1'b0);
    chk1("popwrite_unr", o_unr[0], 1'b0);
    #1 v0 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      goto(1032 + 512 * k);
      chk64($sformatf("drain_level%0d", k), 64'(o_lvl[0]), 64'(4 - k));
      chk1($sformatf("drain_unr%0d", k), o_unr[0], 1'b0);
    end
    goto(3592);
    chk1("drained_underrun", o_unr[0], 1'b1);

    // Three pairs queued, then reset at bit_cnt=40.
    for (int i = 0; i < 3; i++) begin
      goto(3599 + i);
      #1 v0 = 1'b1; l0 = 24'hABC000 + 24'(i); r0 = 24'h123000 + 24'(i);
    end
    goto(3602);
    #1 v0 = 1'b0;
    goto(3603);
    chk64("queued_level", 64'(o_lvl[0]), 64'd3);
    goto(3912);
    #1 rst = 1'b1;
    #1 reset_values("midrst");
    repeat (10) @(negedge clk);
    reset_values("midrst_hold");
    #1 rst = 1'b0;
    goto(3);
    chk1("re_bck3", o_bck[0], 1'b0);
    goto(4);
    chk1("re_bck4", o_bck[0], 1'b1);
    chk1("re_ws4", o_ws[0], 1'b1);
    goto(8);
    chk1("re_bck8", o_bck[0], 1'b0);
    chk1("re_ws8", o_ws[0], 1'b0);
    chk1("re_unr8", o_unr[0], 1'b1);
    chk1("re_data8", o_data[0], 1'b0);
    chk64("re_level8", 64'(o_lvl[0]), 64'd0);
    goto(9);
    chk1("re_unr9", o_unr[0], 1'b0);
    goto(530);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
